// File: rtl/execute_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of execute_stage, bundled as one interface.
// The master modport belongs to the pipeline around the stage; the slave modport belongs to the stage.
interface execute_stage_if;
    logic [15:0] Rd1_IDEX;
    logic [15:0] Rd2_IDEX;
    logic [15:0] Imm_IDEX;
    logic [15:0] PCInc_IDEX;
    logic        ALUSrc_IDEX;
    logic [3:0]  ALUOp_IDEX;
    logic [1:0]  Branch_IDEX;
    logic        MemRead_IDEX;
    logic        MemWrite_IDEX;
    logic        MemtoReg_IDEX;
    logic        RegWrite_IDEX;
    logic        Dump_IDEX;
    logic        halt_IDEX;
    logic [2:0]  WrR_IDEX;

    logic        takeBranch;
    logic [15:0] branchTarget;
    logic        exStall;
    logic [15:0] ALUO_EXMEM;
    logic [15:0] Rd2_EXMEM;
    logic        takeBranch_EXMEM;
    logic        MemRead_EXMEM;
    logic        MemWrite_EXMEM;
    logic        MemtoReg_EXMEM;
    logic        RegWrite_EXMEM;
    logic        Dump_EXMEM;
    logic        halt_EXMEM;
    logic [2:0]  WrR_EXMEM;

    modport master (
        output Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCInc_IDEX, ALUSrc_IDEX, ALUOp_IDEX, Branch_IDEX,
               MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX, WrR_IDEX,
        input  takeBranch, branchTarget, exStall, ALUO_EXMEM, Rd2_EXMEM, takeBranch_EXMEM,
               MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM, WrR_EXMEM
    );

    modport slave (
        input  Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCInc_IDEX, ALUSrc_IDEX, ALUOp_IDEX, Branch_IDEX,
               MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX, WrR_IDEX,
        output takeBranch, branchTarget, exStall, ALUO_EXMEM, Rd2_EXMEM, takeBranch_EXMEM,
               MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM, WrR_EXMEM
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipeline: ALU, branch resolution and the EX/MEM register.
// Define EX_MULT_EN to build the 16-cycle shift-add multiplier that stalls the pipeline on MUL.
module execute_stage (
    input  logic           clk,
    input  logic           rst,
    input  logic           freeze,
    input  logic           flush,
    execute_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_ROL   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SEQ   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [31:0] w_rol;
    logic [15:0] w_alu;
    logic [15:0] w_result;
    logic        w_cond;
    logic        w_stall;
    logic        w_take;

    logic [15:0] r_aluo;
    logic [15:0] r_rd2;
    logic        r_take;
    logic [5:0]  r_ctl;
    logic [2:0]  r_wrr;

    assign w_a   = bus.Rd1_IDEX;
    assign w_b   = bus.ALUSrc_IDEX ? bus.Imm_IDEX : bus.Rd2_IDEX;
    assign w_rol = {w_a, w_a} << w_b[3:0];

    // ALU; MUL and unused opcodes yield 0 here, the multiplier supplies its own result
    always_comb begin
        w_alu = 16'd0;
        case (bus.ALUOp_IDEX)
            OP_ADD:   w_alu = w_a + w_b;
            OP_SUB:   w_alu = w_a - w_b;
            OP_AND:   w_alu = w_a & w_b;
            OP_OR:    w_alu = w_a | w_b;
            OP_XOR:   w_alu = w_a ^ w_b;
            OP_SLL:   w_alu = w_a << w_b[3:0];
            OP_SRL:   w_alu = w_a >> w_b[3:0];
            OP_SRA:   w_alu = $signed(w_a) >>> w_b[3:0];
            OP_ROL:   w_alu = w_rol[31:16];
            OP_SLT:   w_alu = {15'd0, ($signed(w_a) < $signed(w_b))};
            OP_SEQ:   w_alu = {15'd0, (w_a == w_b)};
            OP_PASSB: w_alu = w_b;
            default:  w_alu = 16'd0;
        endcase
    end

    // Branch condition is evaluated on operand A only
    always_comb begin
        w_cond = 1'b0;
        case (bus.Branch_IDEX)
            2'b01:   w_cond = (bus.Rd1_IDEX == 16'd0);
            2'b10:   w_cond = (bus.Rd1_IDEX != 16'd0);
            2'b11:   w_cond = bus.Rd1_IDEX[15];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_take           = w_cond & ~flush & ~w_stall;
    assign bus.takeBranch   = w_take;
    assign bus.branchTarget = bus.PCInc_IDEX + bus.Imm_IDEX;
    assign bus.exStall      = w_stall;

`ifdef EX_MULT_EN
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

    mul_state_t  r_state;
    logic [15:0] r_ma;
    logic [15:0] r_mb;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic        w_start;

    // Stall already covers the issue cycle so the MUL's slot becomes a bubble
    assign w_start  = (r_state == S_IDLE) && (bus.ALUOp_IDEX == OP_MUL) && !flush;
    assign w_stall  = (r_state == S_BUSY) || w_start;
    assign w_result = (r_state == S_DONE) ? r_acc : w_alu;

    // Shift-add multiplier, one multiplier bit per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ma    <= 16'd0;
            r_mb    <= 16'd0;
            r_acc   <= 16'd0;
            r_cnt   <= 4'd0;
        end else if (freeze) begin
            if (flush) begin
                r_state <= S_IDLE;
                r_acc   <= 16'd0;
                r_cnt   <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_ma    <= w_a;
                            r_mb    <= w_b;
                            r_acc   <= 16'd0;
                            r_cnt   <= 4'd0;
                            r_state <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (r_mb[r_cnt]) begin
                            r_acc <= r_acc + (r_ma << r_cnt);
                        end
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd15) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
`else
    assign w_stall  = 1'b0;
    assign w_result = w_alu;
`endif

    // EX/MEM register: bubble on flush or stall, hold while frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluo <= 16'd0;
            r_rd2  <= 16'd0;
            r_take <= 1'b0;
            r_ctl  <= 6'd0;
            r_wrr  <= 3'd0;
        end else if (freeze) begin
            if (flush || w_stall) begin
                r_aluo <= 16'd0;
                r_rd2  <= 16'd0;
                r_take <= 1'b0;
                r_ctl  <= 6'd0;
                r_wrr  <= 3'd0;
            end else begin
                r_aluo <= w_result;
                r_rd2  <= bus.Rd2_IDEX;
                r_take <= w_take;
                r_ctl  <= {bus.MemRead_IDEX, bus.MemWrite_IDEX, bus.MemtoReg_IDEX,
                           bus.RegWrite_IDEX, bus.Dump_IDEX, bus.halt_IDEX};
                r_wrr  <= bus.WrR_IDEX;
            end
        end
    end

    assign bus.ALUO_EXMEM       = r_aluo;
    assign bus.Rd2_EXMEM        = r_rd2;
    assign bus.takeBranch_EXMEM = r_take;
    assign bus.MemRead_EXMEM    = r_ctl[5];
    assign bus.MemWrite_EXMEM   = r_ctl[4];
    assign bus.MemtoReg_EXMEM   = r_ctl[3];
    assign bus.RegWrite_EXMEM   = r_ctl[2];
    assign bus.Dump_EXMEM       = r_ctl[1];
    assign bus.halt_EXMEM       = r_ctl[0];
    assign bus.WrR_EXMEM        = r_wrr;
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 16-bit five-stage pipeline; sits between the ID/EX register and the memory stage. It evaluates the ALU operation, resolves conditional branches, and runs an optional iterative 16-cycle multiplier that stalls the pipeline. It also owns the EX/MEM pipeline register that feeds the memory stage.

## Interface
Parameters: none.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  global pipeline-advance enable; 1 = pipeline registers load, 0 = everything holds
- flush  in  1  squash the instruction currently in EX
- Rd1_IDEX, Rd2_IDEX  in  16  register operands A and B
- Imm_IDEX  in  16  sign-extended immediate
- PCInc_IDEX  in  16  PC+2 of the instruction
- ALUSrc_IDEX  in  1  ALU B source: 1 = Imm, 0 = Rd2
- ALUOp_IDEX  in  4  operation code (see Operation)
- Branch_IDEX  in  2  branch type: 00 none, 01 BEQZ, 10 BNEZ, 11 BLTZ
- MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX  in  1  control bits to pass through
- WrR_IDEX  in  3  destination register
- takeBranch  out  1  combinational branch-taken signal for the current EX instruction
- branchTarget  out  16  combinational value PCInc_IDEX + Imm_IDEX
- exStall  out  1  multiplier busy; the hazard unit must hold PC, IF/ID and ID/EX while this is high
- ALUO_EXMEM, Rd2_EXMEM  out  16  registered ALU result and store data
- takeBranch_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM  out  1  registered control bits
- WrR_EXMEM  out  3  registered destination register

## Operation
- Operands: A = Rd1_IDEX; B = ALUSrc_IDEX ? Imm_IDEX : Rd2_IDEX.
- ALU operations. All results are 16-bit and wrap modulo 2^16. Shift amounts use B[3:0].
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA, 8 ROL
  - 9 SLT: signed compare, result is 1 or 0
  - 10 SEQ: result is 1 or 0
  - 11 PASSB
  - 12 MUL: low 16 bits of A*B
  - 13–15: result 0
- Branches: takeBranch is determined from Rd1_IDEX.
  - BEQZ: taken when Rd1_IDEX == 0.
  - BNEZ: taken when Rd1_IDEX != 0.
  - BLTZ: taken when Rd1_IDEX[15] = 1.
  - takeBranch is forced to 0 when flush = 1 or exStall = 1.
- Multiplier FSM. It uses shift-add and consumes one multiplier bit per cycle. The FSM advances only when freeze = 1.
  - IDLE: when ALUOp_IDEX = 12 and flush = 0, latch A and B, clear the accumulator and count, assert exStall, and go to BUSY.
  - BUSY: if B[count] = 1, accumulator += A << count. Increment count. exStall = 1. Go to DONE after count = 15 is processed, i.e. 16 BUSY cycles.
  - DONE: exStall = 0. The accumulator drives the ALU result and the EX/MEM register loads it. Return to IDLE.
  - Exactly one multiply runs per MUL instruction. In DONE, a MUL still present in ID/EX is not restarted.
- EX/MEM register load, evaluated on each clock edge where freeze = 1:
  - If flush = 1 or exStall = 1, load a bubble: all control bits 0, WrR 0, data 0.
  - Otherwise, load the computed values.
  - When freeze = 0, the register holds.
- flush while the FSM is in BUSY or DONE returns the FSM to IDLE and loads a bubble.
- When flush and a MUL start occur together, flush wins: no start, exStall stays 0.

## Timing
- Reset: all EX/MEM outputs are 0 and the FSM is IDLE. exStall, takeBranch and branchTarget are combinational; exStall = 0 in IDLE.
- Non-MUL instructions: 1-cycle latency; the result appears in the EX/MEM register on the next enabled edge.
- MUL timing:
  - Cycles 0 to 16 (IDLE issue cycle plus 16 BUSY cycles): exStall = 1, 17 bubbles enter MEM.
  - Cycle 17 (DONE): the result loads into EX/MEM.
  - Edge-to-output latency is 18 enabled cycles.
- freeze = 0 during BUSY: count, accumulator and state all hold; the stall is extended by the number of frozen cycles.
- rst asserted mid-multiply: next edge returns to IDLE, clears count and accumulator, zeroes EX/MEM.

## Configuration
- EX_MULT_EN defined: the multiplier FSM is built and MUL behaves as above.
- EX_MULT_EN undefined: there is no FSM, exStall is tied to 0, and ALUOp 12 produces 0 with 1-cycle latency.

## Test plan
- ADD: A = 0x7FFF, B = Imm = 0x0001, ALUSrc = 1 -> next enabled edge ALUO_EXMEM = 0x8000, RegWrite_EXMEM = 1.
- Shifts: SRA with A = 0x8010, B = 4 -> ALUO_EXMEM = 0xF801. ROL with the same operands -> 0x0108.
- BLTZ: Rd1 = 0xFFFE, PCInc = 0x0010, Imm = 0xFFF8 -> takeBranch = 1, branchTarget = 0x0008. Same stimulus with flush = 1 -> takeBranch = 0 and a bubble is loaded.
- MUL with EX_MULT_EN defined: A = 0x0123, B = 0x0011 -> exStall high for 17 cycles with bubbles in EX/MEM, then ALUO_EXMEM = 0x1353. Also hold freeze = 0 for 3 cycles mid-BUSY -> the stall extends to 20 cycles and the result is unchanged.
- MUL interrupted: assert rst at BUSY cycle 8 -> next edge exStall = 0, all EX/MEM outputs are 0. Separately, flush at BUSY cycle 5 -> IDLE and a bubble loads.
- MUL with EX_MULT_EN undefined: any operands -> exStall stays 0 and ALUO_EXMEM = 0 after 1 cycle.
